// File: rtl/dut_seq_pkg.sv
// Shared opcodes, status codes and control-state encoding for the DUT test sequencer.
package dut_seq_pkg;

  localparam logic [1:0] OP_HEAD  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_CALC  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD_SEL = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } seq_state_e;

  // Only WRITE drives the environment with RnW low.
  function automatic logic op_rnw(input logic [1:0] op);
    return (op != OP_WRITE);
  endfunction

endpackage

// File: rtl/dut_test_sequencer_if.sv
// Host-side command/response handshake bundle; master = host decoder, slave = sequencer.
interface dut_test_sequencer_if #(
  parameter int BITWIDTH_DATA   = 16,
  parameter int BITWIDTH_ADR    = 6,
  parameter int NUM_DUT         = 3,
  parameter int NUM_BITS_HEADER = 32
);
  localparam int SEL_W = (NUM_DUT > 1) ? $clog2(NUM_DUT) : 1;

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [1:0]                 cmd_op;
  logic [SEL_W-1:0]           cmd_sel;
  logic [BITWIDTH_ADR-1:0]    cmd_adr;
  logic [BITWIDTH_DATA-1:0]   cmd_data;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [BITWIDTH_DATA-1:0]   rsp_data;
  logic [NUM_BITS_HEADER-1:0] rsp_head;
  logic [1:0]                 rsp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_adr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_head, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_adr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_head, rsp_status
  );

endinterface

// File: rtl/dut_seq_timer.sv
// Saturating WAIT-phase cycle counter; o_tc is high while the count sits at TIMEOUT_CYCLES-1.
module dut_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int              CW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tc;
  logic [CW-1:0] w_cnt_nxt;

  // Next count: clear wins, otherwise step until terminal count and hold there.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en && (r_cnt != TC_VAL)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Count register with terminal flag registered alongside it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tc  <= (w_cnt_nxt == TC_VAL);
    end
  end

  assign o_tc = r_tc;

endmodule

// File: rtl/dut_test_sequencer.sv
// Command-driven sequencer: one host command at a time is turned into select/setup/start/wait
// on the DUT test environment, and the captured result is returned as a held response.
module dut_test_sequencer
  import dut_seq_pkg::*;
#(
  parameter int BITWIDTH_DATA   = 16,
  parameter int BITWIDTH_ADR    = 6,
  parameter int NUM_DUT         = 3,
  parameter int NUM_BITS_HEADER = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  dut_test_sequencer_if.slave        host,
  output logic [((NUM_DUT > 1) ? $clog2(NUM_DUT) : 1)-1:0] o_dut_sel,
  output logic [BITWIDTH_ADR-1:0]    o_dut_adr,
  output logic                       o_dut_rnw,
  output logic [BITWIDTH_DATA-1:0]   o_dut_data_in,
  output logic                       o_dut_start_flag,
  input  logic [BITWIDTH_DATA-1:0]   i_dut_data_out,
  input  logic [NUM_BITS_HEADER-1:0] i_dut_head_info,
  input  logic                       i_dut_rdy_flag
);
  localparam int               SEL_W     = (NUM_DUT > 1) ? $clog2(NUM_DUT) : 1;
  localparam logic [SEL_W:0]   NUM_DUT_L = (SEL_W + 1)'(NUM_DUT);

  seq_state_e                 r_state;
  logic [1:0]                 r_op;
  logic                       r_cmd_ready;
  logic                       r_rsp_valid;
  logic [BITWIDTH_DATA-1:0]   r_rsp_data;
  logic [NUM_BITS_HEADER-1:0] r_rsp_head;
  logic [1:0]                 r_rsp_status;
  logic [SEL_W-1:0]           r_dut_sel;
  logic [BITWIDTH_ADR-1:0]    r_dut_adr;
  logic                       r_dut_rnw;
  logic [BITWIDTH_DATA-1:0]   r_dut_data_in;
  logic                       r_start;
  logic                       r_rdy_prev;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_tc;
  logic w_done;
  logic w_bad_sel;

  assign w_tmr_clr = (r_state == START);
  assign w_tmr_en  = (r_state == WAIT);
  assign w_done    = i_dut_rdy_flag && !r_rdy_prev;
  assign w_bad_sel = ({1'b0, host.cmd_sel} >= NUM_DUT_L);

  dut_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tmr_tc)
  );

  // Control FSM; every host and environment output is a register written here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_op          <= OP_HEAD;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_head    <= '0;
      r_rsp_status  <= ST_OK;
      r_dut_sel     <= '0;
      r_dut_adr     <= '0;
      r_dut_rnw     <= 1'b0;
      r_dut_data_in <= '0;
      r_start       <= 1'b0;
      r_rdy_prev    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (host.cmd_valid && r_cmd_ready) begin
            r_op        <= host.cmd_op;
            r_cmd_ready <= 1'b0;
            if (w_bad_sel) begin
              // Environment lines keep their previous values on a bad select.
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_BAD_SEL;
              r_rsp_data   <= '0;
              r_rsp_head   <= '0;
              r_state      <= RESP;
            end else begin
              r_dut_sel     <= host.cmd_sel;
              r_dut_adr     <= host.cmd_adr;
              r_dut_data_in <= host.cmd_data;
              r_dut_rnw     <= op_rnw(host.cmd_op);
              r_state       <= SETUP;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (r_op == OP_HEAD) begin
            r_rsp_head   <= i_dut_head_info;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_OK;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_start    <= 1'b0;
          r_rdy_prev <= i_dut_rdy_flag;
          r_state    <= WAIT;
        end
        WAIT: begin
          r_rdy_prev <= i_dut_rdy_flag;
          if (w_done) begin
            r_rsp_data   <= i_dut_data_out;
            r_rsp_head   <= i_dut_head_info;
            r_rsp_status <= ST_OK;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else if (w_tmr_tc) begin
            r_rsp_data   <= '0;
            r_rsp_head   <= i_dut_head_info;
            r_rsp_status <= ST_TIMEOUT;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          if (host.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          r_start     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign host.cmd_ready  = r_cmd_ready;
  assign host.rsp_valid  = r_rsp_valid;
  assign host.rsp_data   = r_rsp_data;
  assign host.rsp_head   = r_rsp_head;
  assign host.rsp_status = r_rsp_status;

  assign o_dut_sel        = r_dut_sel;
  assign o_dut_adr        = r_dut_adr;
  assign o_dut_rnw        = r_dut_rnw;
  assign o_dut_data_in    = r_dut_data_in;
  assign o_dut_start_flag = r_start;

endmodule

// File: tb/tb_dut_test_sequencer.sv
// Directed bench for dut_test_sequencer with a small environment model (memory, echo, RDY delay/stuck modes).
module tb_dut_test_sequencer;
  import dut_seq_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int ND = 3;
  localparam int HW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    dut_sel;
  logic [AW-1:0] dut_adr;
  logic          dut_rnw;
  logic [DW-1:0] dut_data_in;
  logic          dut_start;
  logic [DW-1:0] dut_data_out = '0;
  logic [HW-1:0] dut_head = '0;
  logic          dut_rdy = 1'b0;

  dut_test_sequencer_if #(.BITWIDTH_DATA(DW), .BITWIDTH_ADR(AW), .NUM_DUT(ND),
                          .NUM_BITS_HEADER(HW)) bus ();

  dut_test_sequencer #(.BITWIDTH_DATA(DW), .BITWIDTH_ADR(AW), .NUM_DUT(ND),
                       .NUM_BITS_HEADER(HW), .TIMEOUT_CYCLES(TO)) u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .host             (bus.slave),
    .o_dut_sel        (dut_sel),
    .o_dut_adr        (dut_adr),
    .o_dut_rnw        (dut_rnw),
    .o_dut_data_in    (dut_data_in),
    .o_dut_start_flag (dut_start),
    .i_dut_data_out   (dut_data_out),
    .i_dut_head_info  (dut_head),
    .i_dut_rdy_flag   (dut_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment model: 0 = RDY rises in cycle START+1+rdy_delay, 1 = stuck low, 2 = stuck high.
  int            rdy_mode  = 0;
  int            rdy_delay = 1;
  logic          echo      = 1'b0;
  int            n_start   = 0;
  int            rdy_cnt   = 0;
  logic [DW-1:0] mem [64];

  always @(negedge clk) begin
    if (dut_start) begin
      n_start <= n_start + 1;
      rdy_cnt <= rdy_delay + 1;
      if (!dut_rnw) begin
        mem[dut_adr] <= dut_data_in;
        dut_data_out <= dut_data_in;
      end else begin
        dut_data_out <= echo ? dut_data_in : mem[dut_adr];
      end
    end
    case (rdy_mode)
      1: dut_rdy <= 1'b0;
      2: dut_rdy <= 1'b1;
      default: begin
        if (dut_start) begin
          dut_rdy <= 1'b0;
        end else if (rdy_cnt != 0) begin
          rdy_cnt <= rdy_cnt - 1;
          if (rdy_cnt == 1) dut_rdy <= 1'b1;
        end
      end
    endcase
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sel, input logic [AW-1:0] adr,
                      input logic [DW-1:0] data, output int t0);
    @(negedge clk);
    chk("cmd_ready_pre", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    bus.cmd_adr   = adr;
    bus.cmd_data  = data;
    t0 = cyc;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("rsp_seen", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int t0, lat, s0, seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_sel   = 2'd0;
    bus.cmd_adr   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_start", {31'd0, dut_start}, 32'd0);
    chk("rst_dut_sel", {30'd0, dut_sel}, 32'd0);
    chk("rst_rsp_head", bus.rsp_head, 32'd0);
    rst = 1'b0;

    // HEAD, then hold the response for 10 cycles.
    dut_head = 32'h0C3A_1234;
    s0 = n_start;
    send(OP_HEAD, 2'd1, 6'd0, 16'h0000, t0);
    wait_rsp(t0, lat);
    chk("head_lat", lat, 32'd2);
    chk("head_hdr", bus.rsp_head, 32'h0C3A_1234);
    chk("head_status", {30'd0, bus.rsp_status}, 32'd0);
    chk("head_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("head_nostart", n_start - s0, 32'd0);
    dut_head = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_hdr", bus.rsp_head, 32'h0C3A_1234);
      chk("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    take_rsp();

    // WRITE then READ back through the memory model, RDY 3 cycles late.
    rdy_mode = 0; rdy_delay = 3; echo = 1'b0;
    s0 = n_start;
    send(OP_WRITE, 2'd2, 6'd5, 16'hBEEF, t0);
    wait_rsp(t0, lat);
    chk("wr_lat", lat, 32'd7);
    chk("wr_rnw", {31'd0, dut_rnw}, 32'd0);
    chk("wr_sel", {30'd0, dut_sel}, 32'd2);
    chk("wr_adr", {26'd0, dut_adr}, 32'd5);
    chk("wr_din", {16'd0, dut_data_in}, 32'h0000_BEEF);
    chk("wr_starts", n_start - s0, 32'd1);
    chk("wr_status", {30'd0, bus.rsp_status}, 32'd0);
    take_rsp();

    send(OP_READ, 2'd2, 6'd5, 16'h0000, t0);
    wait_rsp(t0, lat);
    chk("rd_lat", lat, 32'd7);
    chk("rd_data", {16'd0, bus.rsp_data}, 32'h0000_BEEF);
    chk("rd_rnw", {31'd0, dut_rnw}, 32'd1);
    chk("rd_hdr", bus.rsp_head, 32'h5555_AAAA);
    take_rsp();

    // Bad select: no environment activity, DUT_SEL keeps 2.
    s0 = n_start;
    send(OP_READ, 2'd3, 6'd9, 16'h1234, t0);
    wait_rsp(t0, lat);
    chk("bad_lat", lat, 32'd1);
    chk("bad_status", {30'd0, bus.rsp_status}, 32'd2);
    chk("bad_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("bad_hdr", bus.rsp_head, 32'd0);
    chk("bad_sel_hold", {30'd0, dut_sel}, 32'd2);
    chk("bad_adr_hold", {26'd0, dut_adr}, 32'd5);
    chk("bad_nostart", n_start - s0, 32'd0);
    take_rsp();

    // CALC against echo, RDY one cycle after START.
    rdy_delay = 1; echo = 1'b1;
    send(OP_CALC, 2'd0, 6'd1, 16'h00A5, t0);
    wait_rsp(t0, lat);
    chk("calc_lat", lat, 32'd5);
    chk("calc_data", {16'd0, bus.rsp_data}, 32'h0000_00A5);
    chk("calc_status", {30'd0, bus.rsp_status}, 32'd0);
    take_rsp();
    echo = 1'b0;

    // Timeouts: RDY stuck low, then stuck high from before START.
    dut_head = 32'hDEAD_0001;
    rdy_mode = 1;
    s0 = n_start;
    send(OP_READ, 2'd1, 6'd5, 16'h0000, t0);
    wait_rsp(t0, lat);
    chk("to0_lat", lat, 32'd19);
    chk("to0_status", {30'd0, bus.rsp_status}, 32'd1);
    chk("to0_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("to0_hdr", bus.rsp_head, 32'hDEAD_0001);
    chk("to0_starts", n_start - s0, 32'd1);
    take_rsp();

    rdy_mode = 2;
    @(negedge clk);
    send(OP_READ, 2'd1, 6'd5, 16'h0000, t0);
    wait_rsp(t0, lat);
    chk("to1_lat", lat, 32'd19);
    chk("to1_status", {30'd0, bus.rsp_status}, 32'd1);
    chk("to1_data", {16'd0, bus.rsp_data}, 32'd0);
    take_rsp();

    // Reset while in WAIT drops the command.
    rdy_mode = 1;
    send(OP_READ, 2'd1, 6'd5, 16'h0000, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("mid_rst_no_rsp", seen, 32'd0);

    rdy_mode = 0;
    send(OP_HEAD, 2'd2, 6'd0, 16'h0000, t0);
    wait_rsp(t0, lat);
    chk("recover_lat", lat, 32'd2);
    chk("recover_hdr", bus.rsp_head, 32'hDEAD_0001);
    take_rsp();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
